gray_code_counter: RTL
======================

// Module: gray_code_counter
// PURPOSE
//  Parametrised registered binary/Gray counter with a side-channel code converter.
//  - Keeps a WIDTH-bit binary count and publishes it in binary and reflected Gray form.
//  - Supports up/down counting, synchronous load, and wrap or saturate at the ends.
//  - Converts binary->Gray or Gray->binary on a valid-qualified path with 1-cycle latency.
//  - Feeds clock-domain pointer logic and position encoders.
// PARAMETERS
//  WIDTH  4  counter and converter data width in bits; legal range is 2..32
//  WRAP   1  1 = wrap at the ends (modulo 2^WIDTH); 0 = saturate at all-ones (up) or zero (down)
// PORTS
//  clk          input   1      rising-edge clock
//  rst_n        input   1      asynchronous active-low reset
//  en           input   1      count enable, one step per clock
//  up_dn        input   1      1 = count up, 0 = count down
//  load         input   1      synchronous load of load_val; has priority over en
//  load_val     input   WIDTH  binary load value
//  bin_out      output  WIDTH  registered binary count
//  gray_out     output  WIDTH  registered Gray code of the count
//  tc           output  1      terminal-count pulse, one cycle wide
//  conv_in_vld  input   1      converter input is valid this cycle
//  conv_dir     input   1      0 = binary->Gray, 1 = Gray->binary
//  conv_in      input   WIDTH  converter operand
//  conv_out     output  WIDTH  registered converter result
//  conv_out_vld output  1      conv_out is valid this cycle
// BEHAVIOUR
//  Reset
//  - rst_n low clears bin_out, gray_out, tc, conv_out and conv_out_vld to 0 immediately.
//  - Reset is asynchronous, including mid-count. Release is synchronous to clk.
//  Counter update, evaluated at each rising clk edge
//  - load=1: bin_out<=load_val; gray_out<=load_val^(load_val>>1); tc<=0. en is ignored.
//  - load=0, en=1, up_dn=1: next = bin_out+1.
//      At all-ones, WRAP=1 gives 0; WRAP=0 holds all-ones.
//  - load=0, en=1, up_dn=0: next = bin_out-1.
//      At 0, WRAP=1 gives all-ones; WRAP=0 holds 0.
//  - load=0, en=0: bin_out and gray_out hold; tc<=0.
//  Output relationship and timing
//  - gray_out is always next^(next>>1). It is registered in the same edge as bin_out, never lagging.
//  - Every count step, including the wrap step, changes exactly one gray_out bit.
//  - A saturated hold changes no bit.
//  Terminal count
//  - tc<=1 for one cycle on any enabled step that wraps (WRAP=1).
//  - tc<=1 for one cycle on any enabled step blocked at saturation (WRAP=0).
//  - tc<=0 otherwise.
//  - Continuous enable at saturation with WRAP=0 keeps tc high every cycle.
//  Converter, independent of the counter state
//  - Binary->Gray: g = b^(b>>1).
//  - Gray->binary: b[i] = ^g[WIDTH-1:i] (prefix XOR from the MSB down).
//  - Latency: conv_in_vld=1 at edge N gives conv_out=result and conv_out_vld=1 after edge N.
//  - conv_in_vld=0: conv_out_vld<=0 and conv_out holds its last value.
//  - Back-to-back valid inputs give back-to-back results; there is no stall or backpressure.
//  Simultaneous events
//  - The counter and converter operate concurrently.
//  - load and en together: load wins.
//  - up_dn may change every cycle; each step uses the up_dn value sampled at that edge.
// TESTING
//  1. Reset: drive rst_n=0 mid-count at gray_out=0110.
//     -> All outputs read 0 before the next clk edge; counting resumes from 0 after release.
//  2. WIDTH=4, WRAP=1, up, en=1 for 17 clocks.
//     -> gray_out runs 0000,0001,0011,0010,0110,...,1000,0000.
//     -> tc=1 only on the 1111->0000 step; the bench checks a 1-bit Hamming distance on every step.
//  3. From 0 with up_dn=0, en=1.
//     -> bin_out=1111, gray_out=1000, tc=1 for one cycle.
//     -> Next step gives bin_out=1110, gray_out=1001, tc=0.
//  4. load=1, en=1, load_val=1010.
//     -> bin_out=1010, gray_out=1111, tc=0 (load priority).
//  5. WRAP=0: load 1111, then up with en=1 for 3 cycles.
//     -> bin_out holds 1111, gray_out holds 1000, tc=1 each cycle.
//  6. Converter, stream of valid inputs:
//     -> conv_dir=0, conv_in=1011 gives conv_out=1110.
//     -> conv_dir=1, conv_in=1110 gives conv_out=1011.
//     -> Each result arrives one cycle later with conv_out_vld=1; vld drops the cycle after conv_in_vld=0.

Source files
------------

// File: rtl/gray_code_counter_if.sv
// Counter/converter bus: the master drives the controls and operands, and the slave returns
// the registered count and the converter results.
interface gray_code_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  logic             conv_in_vld;
  logic             conv_dir;
  logic [WIDTH-1:0] conv_in;
  logic [WIDTH-1:0] conv_out;
  logic             conv_out_vld;

  modport master (
    output en, up_dn, load, load_val, conv_in_vld, conv_dir, conv_in,
    input  bin_out, gray_out, tc, conv_out, conv_out_vld
  );

  modport slave (
    input  en, up_dn, load, load_val, conv_in_vld, conv_dir, conv_in,
    output bin_out, gray_out, tc, conv_out, conv_out_vld
  );
endinterface

// File: rtl/gray_code_counter.sv
// Registered binary/Gray up/down counter with wrap or saturate ends and terminal-count pulse,
// plus an independent 1-cycle binary<->Gray converter.
module gray_code_counter #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_code_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] next_bin;
  logic             next_tc;
  logic [WIDTH-1:0] b2g;
  logic [WIDTH-1:0] g2b;

  always_comb begin
    next_bin = bus.bin_out;
    next_tc  = 1'b0;
    if (bus.load) begin
      next_bin = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (bus.bin_out == MAX) begin
          next_tc  = 1'b1;
          next_bin = WRAP ? '0 : MAX;
        end else begin
          next_bin = bus.bin_out + 1'b1;
        end
      end else begin
        if (bus.bin_out == '0) begin
          next_tc  = 1'b1;
          next_bin = WRAP ? MAX : '0;
        end else begin
          next_bin = bus.bin_out - 1'b1;
        end
      end
    end
  end

  // Gray is encoded from next_bin so both outputs update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bin_out  <= '0;
      bus.gray_out <= '0;
      bus.tc       <= 1'b0;
    end else begin
      bus.bin_out  <= next_bin;
      bus.gray_out <= next_bin ^ (next_bin >> 1);
      bus.tc       <= next_tc;
    end
  end

  always_comb begin
    b2g = bus.conv_in ^ (bus.conv_in >> 1);
    g2b = '0;
    g2b[WIDTH-1] = bus.conv_in[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      g2b[WIDTH-1-i] = g2b[WIDTH-i] ^ bus.conv_in[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.conv_out     <= '0;
      bus.conv_out_vld <= 1'b0;
    end else begin
      bus.conv_out_vld <= bus.conv_in_vld;
      if (bus.conv_in_vld) begin
        bus.conv_out <= bus.conv_dir ? g2b : b2g;
      end
    end
  end
endmodule
